writeback_unit: RTL and testbench
=================================

# writeback_unit

Parametrised successor to the pipeline's write-back result select. It registers the MEM/WB boundary and selects the register-file write data from ALU result, aligned and extended load data, or link address. It also waits on a variable-latency data-memory response with a stall handshake. It sits between the MEM stage / data memory and the register file / forwarding network.

## Interface
Parameters:
- DATA_W, 32: datapath width; legal values are 32 and 64.
- REG_AW, 5: register-address width.
- TIMEOUT_CYC, 255: maximum load-wait cycles; used only with WB_LOAD_TIMEOUT_EN.

Ports (reset is asynchronous, active-high; one clock):
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- ValidM, input, 1: the MEM-stage instruction is valid.
- RegWriteM, input, 1: the instruction writes the register file.
- ResultSrcM, input, 2: result source; 00 = ALU, 01 = load, 10 = link, 11 = reserved (treated as ALU).
- WriteRegM, input, REG_AW: destination register.
- ALUOutM, input, DATA_W: ALU result or load address.
- PCPlus4M, input, DATA_W: link value.
- LoadSizeM, input, 2: 00 = byte, 01 = half, 10 = word, 11 = dword.
- LoadSignedM, input, 1: 1 = sign-extend, 0 = zero-extend.
- ReadDataM, input, DATA_W: raw memory read word.
- ReadValidM, input, 1: ReadDataM is valid this cycle.
- FlushW, input, 1: squash the instruction entering W.
- StallM, output, 1: freeze the MEM stage and all upstream stages.
- RegWriteW, output, 1: register-file write enable.
- WriteRegW, output, REG_AW: register-file write address.
- ResultW, output, DATA_W: register-file write data.
- LoadErrW, output, 1: load timed out; exists only with WB_LOAD_TIMEOUT_EN.

## Operation
- FSM states: IDLE and WAIT.
- A load is ValidM=1 with ResultSrcM=01.
- In IDLE, a load with ReadValidM=0 moves the FSM to WAIT. StallM=1 combinationally in that cycle.
- In IDLE, a load with ReadValidM=1 completes in the same cycle, with no stall.
- In WAIT, StallM = ~ReadValidM.
  - On ReadValidM=1, the load is captured and the FSM returns to IDLE. StallM=0 in that cycle.
  - MEM inputs are held stable by upstream while StallM=1.
- W-register capture on a non-stalled edge:
  - RegWriteW <= ValidM & RegWriteM & ~FlushW.
  - WriteRegW <= WriteRegM.
  - ResultW <= the selected value.
- W-register capture on a stalled edge: RegWriteW <= 0 (a bubble). WriteRegW and ResultW hold their values.
- FlushW in WAIT:
  - The FSM returns to IDLE and StallM drops immediately.
  - The pending response is dropped.
  - RegWriteW <= 0.
- Load alignment:
  - The byte offset is ALUOutM[log2(DATA_W/8)-1:0].
  - The selected lane is ReadDataM >> (8*offset), truncated to the access size, then sign- or zero-extended to DATA_W.
  - Misaligned half, word, or dword accesses use the offset with the low bits forced to 0.
- When DATA_W=32, LoadSizeM=11 behaves as word.
- Link result = PCPlus4M, passed through unmodified.

## Timing
- Reset values:
  - FSM = IDLE.
  - RegWriteW = 0, WriteRegW = 0, ResultW = 0.
  - LoadErrW = 0.
  - StallM = 0; it is combinational from the FSM state and inputs, so it reads 0 while rst is high.
- Latency: ALU and link results appear on ResultW one cycle after the M cycle.
- A load appears one cycle after the cycle in which ReadValidM=1.
- ReadValidM is ignored when no load is present or pending.
- Reset during WAIT aborts the load. No write occurs.

## Configuration
- WB_LOAD_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on entering WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYC with ReadValidM still 0, the load completes with ResultW <= 0, RegWriteW <= 0, and LoadErrW <= 1 for one cycle. The FSM returns to IDLE.
  - LoadErrW resets to 0.
- WB_LOAD_TIMEOUT_EN undefined:
  - No counter and no LoadErrW port.
  - WAIT persists until ReadValidM or FlushW.

## Test plan
- **ALU op:** ALUOutM=0x12345678, WriteRegM=3, RegWriteM=1 → next cycle RegWriteW=1, WriteRegW=3, ResultW=0x12345678.
- **Signed byte load, 1-cycle response:** ReadDataM=0x80FF7F01, offset=3, ReadValidM same cycle → ResultW=0xFFFFFF80, StallM never 1.
- **Zero-extended half load:** same ReadDataM, offset=2, LoadSignedM=0 → ResultW=0x000080FF.
- **3-cycle latency load:** StallM=1 for 3 cycles, RegWriteW=0 during them. ReadValidM in the 4th cycle → StallM=0 that cycle, and the word is written the next cycle.
- **FlushW in WAIT:** StallM drops the same cycle, no write occurs, and the FSM is IDLE after the edge. Reset asserted mid-WAIT gives all outputs 0.
- **Timeout, macro defined, TIMEOUT_CYC=4:** no ReadValidM → LoadErrW pulses one cycle, RegWriteW=0, StallM released.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit
//   Registers the MEM/WB pipeline boundary and selects the register-file
//   write data: the ALU result, aligned and extended load data, or the link
//   address. A load whose data-memory response is not ready in its own cycle
//   parks the FSM in WAIT and stalls MEM and everything upstream until the
//   response arrives or the instruction is flushed.
//
//   Optional feature macro: WB_LOAD_TIMEOUT_EN
//     When defined, a load that waits TIMEOUT_CYC WAIT cycles is abandoned.
//     Abandoning it releases the stall and pulses LoadErrW for one cycle.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     ValidM            MEM-stage instruction valid
//     RegWriteM         instruction writes the register file
//     ResultSrcM        00 ALU, 01 load, 10 link, 11 ALU
//     WriteRegM         destination register
//     ALUOutM           ALU result / load address
//     PCPlus4M          link value
//     LoadSizeM         00 byte, 01 half, 10 word, 11 dword
//     LoadSignedM       1 = sign-extend loaded value
//     ReadDataM         raw memory read word
//     ReadValidM        ReadDataM valid this cycle
//     FlushW            squash the instruction entering W
//     StallM            freeze MEM and upstream (combinational)
//     RegWriteW         register-file write enable
//     WriteRegW         register-file write address
//     ResultW           register-file write data
//     LoadErrW          load timeout pulse (WB_LOAD_TIMEOUT_EN only)
module writeback_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [1:0]        LoadSizeM,
  input  logic              LoadSignedM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic              ReadValidM,
  input  logic              FlushW,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  output logic              LoadErrW
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              is_load;
  logic              timeout_hit;
  logic              stall;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] result_sel;

  // Shift the addressed lane down to bit 0, then truncate and extend it.
  // Misaligned half/word/dword accesses ignore the low offset bits.
  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] raw,
    input logic [OFF_W-1:0]  offset,
    input logic [1:0]        size,
    input logic              sign_ext
  );
    logic [OFF_W-1:0]  lane;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;
    lane = offset;
    case (size)
      2'b00: lane = offset;
      2'b01: lane[0] = 1'b0;
      2'b10: lane[1:0] = 2'b00;
      2'b11: lane = {OFF_W{1'b0}};
      default: lane = offset;
    endcase
    shifted = raw >> {lane, 3'b000};
    // With a 32-bit datapath a dword access is simply a word access.
    case (size)
      2'b00: begin keep = DATA_W'(8'hFF);            msb = shifted[7];  end
      2'b01: begin keep = DATA_W'(16'hFFFF);         msb = shifted[15]; end
      2'b10: begin keep = DATA_W'(32'hFFFF_FFFF);    msb = shifted[31]; end
      default: begin keep = {DATA_W{1'b1}};          msb = shifted[DATA_W-1]; end
    endcase
    return (shifted & keep) | ((sign_ext & msb) ? ~keep : {DATA_W{1'b0}});
  endfunction

  assign is_load    = ValidM & (ResultSrcM == 2'b01);
  assign load_value = align_load(ReadDataM, ALUOutM[OFF_W-1:0], LoadSizeM, LoadSignedM);

  // Result source mux; the reserved encoding falls back to the ALU result.
  always_comb begin
    result_sel = ALUOutM;
    case (ResultSrcM)
      2'b01:   result_sel = load_value;
      2'b10:   result_sel = PCPlus4M;
      default: result_sel = ALUOutM;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt;

  // The counter runs only while waiting, so it is zero on every WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end else begin
      wait_cnt <= {CNT_W{1'b0}};
    end
  end

  assign timeout_hit = (state == WAIT) & ~ReadValidM & ~FlushW & (wait_cnt == CNT_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  // Stall decision and next state for the load-wait FSM.
  always_comb begin
    stall      = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (is_load & ~ReadValidM) begin
          stall      = 1'b1;
          state_next = WAIT;
        end else begin
          stall      = 1'b0;
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (FlushW | ReadValidM | timeout_hit) begin
          stall      = 1'b0;
          state_next = IDLE;
        end else begin
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      default: begin
        stall      = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Reset forces the state to IDLE, but the inputs may still show a pending
  // load, so the stall is masked explicitly while rst is high.
  assign StallM = stall & ~rst;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // W-stage registers: a stalled edge inserts a bubble and holds the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      WriteRegW <= {REG_AW{1'b0}};
      ResultW   <= {DATA_W{1'b0}};
`ifdef WB_LOAD_TIMEOUT_EN
      LoadErrW  <= 1'b0;
`endif
    end else if (stall) begin
      RegWriteW <= 1'b0;
      WriteRegW <= WriteRegW;
      ResultW   <= ResultW;
`ifdef WB_LOAD_TIMEOUT_EN
      LoadErrW  <= 1'b0;
`endif
    end else if (timeout_hit) begin
      RegWriteW <= 1'b0;
      WriteRegW <= WriteRegM;
      ResultW   <= {DATA_W{1'b0}};
`ifdef WB_LOAD_TIMEOUT_EN
      LoadErrW  <= 1'b1;
`endif
    end else begin
      RegWriteW <= ValidM & RegWriteM & ~FlushW;
      WriteRegW <= WriteRegM;
      ResultW   <= result_sel;
`ifdef WB_LOAD_TIMEOUT_EN
      LoadErrW  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit (DATA_W = 32). Results are compared
// against a byte-arithmetic load model and a tracked copy of the last value
// written to ResultW.
module tb_writeback_unit;

  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, LoadSignedM, ReadValidM, FlushW;
  logic [1:0]  ResultSrcM, LoadSizeM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, PCPlus4M, ReadDataM;
  logic        StallM, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
`ifdef WB_LOAD_TIMEOUT_EN
  logic        LoadErrW;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  writeback_unit #(.DATA_W(32), .REG_AW(5), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .PCPlus4M(PCPlus4M), .LoadSizeM(LoadSizeM), .LoadSignedM(LoadSignedM),
    .ReadDataM(ReadDataM), .ReadValidM(ReadValidM), .FlushW(FlushW),
    .StallM(StallM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW)
`ifdef WB_LOAD_TIMEOUT_EN
    , .LoadErrW(LoadErrW)
`endif
  );

  always #5 clk = ~clk;

  // Reference load: pick the naturally aligned bytes, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sgn);
    longint unsigned nbytes, off, span, v, d;
    logic [63:0] r;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = ((addr % 4) / nbytes) * nbytes;
    span   = 64'd1 << (8 * nbytes);
    d      = data;
    v      = (d >> (8 * off)) % span;
    if (sgn && v >= span / 2) v = v - span;
    r = v;
    return r[31:0];
  endfunction

  task automatic set_op(input logic v, input logic rw, input logic [1:0] src, input logic [4:0] rd_reg,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [1:0] size,
                        input logic sgn, input logic [31:0] rdata, input logic rv, input logic fl);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; WriteRegM = rd_reg; ALUOutM = alu;
    PCPlus4M = pc; LoadSizeM = size; LoadSignedM = sgn; ReadDataM = rdata;
    ReadValidM = rv; FlushW = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    // A pending load on the inputs must not raise StallM during reset.
    set_op(1'b1, 1'b1, 2'b01, 5'd7, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", StallM); end
    step();
    checks++;
    if (RegWriteW !== 1'b0 || WriteRegW !== 5'd0 || ResultW !== 32'h0) begin
      errors++; $display("FAIL reset_regs got %b %0d %h want 0 0 0", RegWriteW, WriteRegW, ResultW);
    end
    set_op(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    last_res = 32'h0;
    step();
  endtask

  task automatic test_alu_link;
    logic v, rw, fl, rv;
    logic [1:0] src;
    logic [4:0] r;
    logic [31:0] a, p, ew;
    for (int n = 0; n < 25; n++) begin
      if (n == 0) begin
        v = 1'b1; rw = 1'b1; fl = 1'b0; src = 2'b00; r = 5'd3; a = 32'h1234_5678; p = 32'h0;
      end else begin
        v = 1'($urandom); rw = 1'($urandom); fl = (($urandom % 4) == 0);
        src = ((n % 3) == 0) ? 2'b00 : ((n % 3) == 1) ? 2'b10 : 2'b11;
        r = 5'($urandom); a = $urandom; p = $urandom;
      end
      rv = 1'($urandom);
      set_op(v, rw, src, r, a, p, 2'($urandom), 1'($urandom), $urandom, rv, fl);
      ew = (src == 2'b10) ? p : a;
      @(negedge clk);
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall n=%0d got %b want 0", n, StallM); end
      step();
      checks++;
      if (RegWriteW !== (v & rw & ~fl) || WriteRegW !== r || ResultW !== ew) begin
        errors++;
        $display("FAIL alu_result n=%0d got %b %0d %h want %b %0d %h", n, RegWriteW, WriteRegW, ResultW,
                 v & rw & ~fl, r, ew);
      end
      last_res = ew;
    end
  endtask

  task automatic test_load;
    logic [31:0] data, addr, ew;
    logic [1:0] size;
    logic sgn, rw;
    logic [4:0] r;
    int lat;
    for (int n = 0; n < 30; n++) begin
      case (n)
        0: begin data = 32'h80FF_7F01; addr = 32'h0000_1003; size = 2'b00; sgn = 1'b1; lat = 0; ew = 32'hFFFF_FF80; end
        1: begin data = 32'h80FF_7F01; addr = 32'h0000_1002; size = 2'b01; sgn = 1'b0; lat = 0; ew = 32'h0000_80FF; end
        2: begin data = 32'hCAFE_BABE; addr = 32'h0000_2000; size = 2'b10; sgn = 1'b0; lat = 3; ew = 32'hCAFE_BABE; end
        default: begin
          data = $urandom; addr = $urandom; size = 2'($urandom); sgn = 1'($urandom);
          lat = $urandom_range(0, 4); ew = ref_load(data, addr, size, sgn);
        end
      endcase
      rw = (n < 3) ? 1'b1 : 1'($urandom);
      r = 5'($urandom);
      set_op(1'b1, rw, 2'b01, r, addr, $urandom, size, sgn, (lat == 0) ? data : $urandom,
             (lat == 0), 1'b0);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL load_wait_stall n=%0d c=%0d got %b want 1", n, c, StallM); end
        step();
        checks++;
        if (RegWriteW !== 1'b0 || ResultW !== last_res) begin
          errors++; $display("FAIL load_bubble n=%0d c=%0d got %b %h want 0 %h", n, c, RegWriteW, ResultW, last_res);
        end
        ReadValidM = (c == lat - 1);
        ReadDataM  = (c == lat - 1) ? data : $urandom;
      end
      @(negedge clk);
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL load_done_stall n=%0d got %b want 0", n, StallM); end
      step();
      checks++;
      if (RegWriteW !== rw || WriteRegW !== r || ResultW !== ew) begin
        errors++;
        $display("FAIL load_result n=%0d got %b %0d %h want %b %0d %h", n, RegWriteW, WriteRegW, ResultW, rw, r, ew);
      end
      last_res = ew;
    end
  endtask

  task automatic test_flush_wait;
    logic [31:0] a, d2;
    a = $urandom;
    set_op(1'b1, 1'b1, 2'b01, 5'd9, a, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got %b want 1", StallM); end
    step();
    FlushW = 1'b1;
    d2 = $urandom; ReadDataM = d2;
    @(negedge clk);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", StallM); end
    step();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_write got %b want 0", RegWriteW); end
    last_res = ref_load(d2, a, 2'b10, 1'b0);
    // A stray response after the flush must be ignored by an IDLE FSM.
    set_op(1'b1, 1'b1, 2'b00, 5'd11, 32'h0BAD_F00D, 32'h0, 2'b00, 1'b0, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", StallM); end
    step();
    checks++;
    if (RegWriteW !== 1'b1 || WriteRegW !== 5'd11 || ResultW !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL flush_next_op got %b %0d %h want 1 11 0badf00d", RegWriteW, WriteRegW, ResultW);
    end
    last_res = 32'h0BAD_F00D;
  endtask

  task automatic test_reset_in_wait;
    set_op(1'b1, 1'b1, 2'b01, 5'd5, 32'h4, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (StallM !== 1'b0 || RegWriteW !== 1'b0 || WriteRegW !== 5'd0 || ResultW !== 32'h0) begin
      errors++; $display("FAIL reset_wait got %b %b %0d %h want 0 0 0 0", StallM, RegWriteW, WriteRegW, ResultW);
    end
    step();
    rst = 1'b0;
    last_res = 32'h0;
    set_op(1'b0, 1'b1, 2'b01, 5'd5, 32'h4, 32'h0, 2'b10, 1'b0, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_wait_stall got %b want 0", StallM); end
    step();
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_wait_write got %b want 0", RegWriteW); end
    last_res = ResultW;
  endtask

`ifdef WB_LOAD_TIMEOUT_EN
  task automatic test_timeout;
    int stalls = 0;
    set_op(1'b1, 1'b1, 2'b01, 5'd6, 32'h8, 32'h0, 2'b10, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (StallM !== 1'b1) break;
      stalls++;
      step();
    end
    checks++;
    if (stalls < TO_CYC || stalls > TO_CYC + 1) begin
      errors++; $display("FAIL timeout_stalls got %0d want %0d..%0d", stalls, TO_CYC, TO_CYC + 1);
    end
    step();
    checks++;
    if (LoadErrW !== 1'b1 || RegWriteW !== 1'b0 || ResultW !== 32'h0) begin
      errors++; $display("FAIL timeout_err got %b %b %h want 1 0 0", LoadErrW, RegWriteW, ResultW);
    end
    set_op(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    checks++; if (LoadErrW !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", LoadErrW); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_link();
    test_load();
    test_flush_wait();
    test_reset_in_wait();
`ifdef WB_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
